// File: rtl/cmp_unit_pipe.sv
// -----------------------------------------------------------------------------
// cmp_unit_pipe
// Two-stage pipelined compare unit for the ALU. One operation per cycle is
// accepted over a valid/ready handshake. Besides the EQ/GT/LT codes it offers
// three-way MIN/MAX with a data result, a running-minimum register (RM) and a
// saturating count of true EQ results.
//
// Optional feature macro: CMP_SIGNED_EN
//   defined   -> A, B and RM compare as two's complement (EQ unaffected),
//                RM initialises to the most positive value (0 then all ones).
//   undefined -> all comparisons unsigned, RM initialises to all ones.
//
// Ports:
//   CLK         clock, rising edge
//   RST         asynchronous active-low reset
//   A, B        operands (DATA_WIDTH)
//   ALU_FUNC    operation select (3)
//   CMP_enable  input valid
//   CMP_ready   input ready (combinational from OUT_READY and CMP_Flag)
//   CMP_OUT     compare code (2)
//   CMP_DATA    data result (DATA_WIDTH)
//   CMP_Flag    output valid
//   OUT_READY   downstream ready
//   MATCH_CNT   saturating count of true EQ results (CNT_WIDTH)
// -----------------------------------------------------------------------------
module cmp_unit_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [2:0]            ALU_FUNC,
  input  logic                  CMP_enable,
  output logic                  CMP_ready,
  output logic [1:0]            CMP_OUT,
  output logic [DATA_WIDTH-1:0] CMP_DATA,
  output logic                  CMP_Flag,
  input  logic                  OUT_READY,
  output logic [CNT_WIDTH-1:0]  MATCH_CNT
);

`ifdef CMP_SIGNED_EN
  localparam logic [DATA_WIDTH-1:0] RM_INIT = {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
  localparam logic [DATA_WIDTH-1:0] RM_INIT = {DATA_WIDTH{1'b1}};
`endif
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

  localparam logic [2:0] F_NOP  = 3'b000;
  localparam logic [2:0] F_EQ   = 3'b001;
  localparam logic [2:0] F_GT   = 3'b010;
  localparam logic [2:0] F_LT   = 3'b011;
  localparam logic [2:0] F_MIN  = 3'b100;
  localparam logic [2:0] F_MAX  = 3'b101;
  localparam logic [2:0] F_RMIN = 3'b110;
  localparam logic [2:0] F_CLR  = 3'b111;

  // Ordering used by every magnitude compare; EQ uses plain equality.
  function automatic logic lt_f(input logic [DATA_WIDTH-1:0] x,
                                input logic [DATA_WIDTH-1:0] y);
`ifdef CMP_SIGNED_EN
    return $signed(x) < $signed(y);
`else
    return x < y;
`endif
  endfunction

  // Three-way code: 01 equal, 10 first greater, 11 first smaller.
  function automatic logic [1:0] code3_f(input logic [DATA_WIDTH-1:0] x,
                                         input logic [DATA_WIDTH-1:0] y);
    logic [1:0] c;
    if (x == y) begin
      c = 2'b01;
    end else if (lt_f(x, y)) begin
      c = 2'b11;
    end else begin
      c = 2'b10;
    end
    return c;
  endfunction

  logic                  s1_valid_q;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_b_q;
  logic [2:0]            s1_func_q;
  logic [1:0]            out_q, out_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  flag_q, flag_d;
  logic [DATA_WIDTH-1:0] rm_q, rm_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  advance_s;

  // The whole pipe moves only when the output slot is empty or being consumed.
  assign advance_s = !flag_q || OUT_READY;
  assign CMP_ready = advance_s;
  assign CMP_OUT   = out_q;
  assign CMP_DATA  = data_q;
  assign CMP_Flag  = flag_q;
  assign MATCH_CNT = cnt_q;

  // Stage 1: capture the accepted operation.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= DATA_ZERO;
      s1_b_q     <= DATA_ZERO;
      s1_func_q  <= F_NOP;
    end else if (advance_s) begin
      s1_valid_q <= CMP_enable;
      if (CMP_enable) begin
        s1_a_q    <= A;
        s1_b_q    <= B;
        s1_func_q <= ALU_FUNC;
      end
    end
  end

  // Stage 2: evaluate the operation and the RM / match-count updates.
  always_comb begin
    out_d  = out_q;
    data_d = data_q;
    flag_d = flag_q;
    rm_d   = rm_q;
    cnt_d  = cnt_q;
    if (advance_s) begin
      // Results default to zero so a bubble leaves clean outputs.
      flag_d = s1_valid_q;
      out_d  = 2'b00;
      data_d = DATA_ZERO;
      if (s1_valid_q) begin
        case (s1_func_q)
          F_NOP: begin
            out_d = 2'b00;
          end
          F_EQ: begin
            if (s1_a_q == s1_b_q) begin
              out_d = 2'b01;
              cnt_d = (cnt_q != CNT_MAX) ? (cnt_q + CNT_ONE) : cnt_q;
            end else begin
              out_d = 2'b00;
            end
          end
          F_GT: begin
            out_d = lt_f(s1_b_q, s1_a_q) ? 2'b10 : 2'b00;
          end
          F_LT: begin
            out_d = lt_f(s1_a_q, s1_b_q) ? 2'b11 : 2'b00;
          end
          F_MIN: begin
            out_d  = code3_f(s1_a_q, s1_b_q);
            data_d = lt_f(s1_a_q, s1_b_q) ? s1_a_q : s1_b_q;
          end
          F_MAX: begin
            out_d  = code3_f(s1_a_q, s1_b_q);
            data_d = lt_f(s1_a_q, s1_b_q) ? s1_b_q : s1_a_q;
          end
          F_RMIN: begin
            // Compare against the RM value left by the previous operation.
            out_d  = code3_f(s1_a_q, rm_q);
            rm_d   = lt_f(s1_a_q, rm_q) ? s1_a_q : rm_q;
            data_d = lt_f(s1_a_q, rm_q) ? s1_a_q : rm_q;
          end
          F_CLR: begin
            rm_d  = RM_INIT;
            cnt_d = CNT_ZERO;
          end
          default: begin
            out_d = 2'b00;
          end
        endcase
      end else begin
        rm_d  = rm_q;
        cnt_d = cnt_q;
      end
    end else begin
      flag_d = flag_q;
    end
  end

  // Stage 2 result and state registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_q  <= 2'b00;
      data_q <= DATA_ZERO;
      flag_q <= 1'b0;
      rm_q   <= RM_INIT;
      cnt_q  <= CNT_ZERO;
    end else begin
      out_q  <= out_d;
      data_q <= data_d;
      flag_q <= flag_d;
      rm_q   <= rm_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
